// File: rtl/trace_release_queue.sv
// Timestamp-gated trace release queue: buffers parsed trace entries in a FIFO and
// releases each one to the request path once the cycle counter reaches its time.
package trace_release_queue_pkg;
    typedef enum logic [1:0] {NOP = 2'd0, READ = 2'd1, WRITE = 2'd2, FETCH = 2'd3} parsed_op_t;
endpackage

// state | meaning
// EMPTY | output register free, out_valid=0, fields cleared
// HOLD  | released entry presented, fields stable until out_ready
module trace_release_queue
    import trace_release_queue_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 33,
    parameter int TIME_WIDTH    = 64,
    parameter int DEPTH         = 8,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TIME_WIDTH-1:0]    in_time,
    input  parsed_op_t               in_op,
    input  logic [ADDRESS_WIDTH-1:0] in_address,
    input  logic                     skip_idle,
    output logic                     out_valid,
    input  logic                     out_ready,
    output parsed_op_t               opcode,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [TIME_WIDTH-1:0]    out_time,
    output logic                     out_late,
    output logic [TIME_WIDTH-1:0]    cycle_count,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     order_err,
    output logic [STAT_WIDTH-1:0]    stall_cycles
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    logic [TIME_WIDTH-1:0]    mem_time [DEPTH];
    parsed_op_t               mem_op   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_addr [DEPTH];

    state_t                state_q;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [OW-1:0]         count_q;
    logic [TIME_WIDTH-1:0] last_time;

    logic                  push, pop, fifo_ne, head_due, fast_fwd;
    logic [TIME_WIDTH-1:0] head_time, cycle_next;
    logic [TIME_WIDTH:0]   cycle_inc;

    assign occupancy = count_q;
    assign in_ready  = (count_q != OW'(DEPTH));
    assign out_valid = (state_q == HOLD);
    assign push      = in_valid && in_ready;
    assign fifo_ne   = (count_q != '0);
    assign head_time = mem_time[rd_ptr];
    assign head_due  = fifo_ne && (head_time <= cycle_count);
    assign pop       = head_due && (!out_valid || out_ready);

    // Widened increment so the fast-forward compare cannot wrap at the top of the range.
    assign cycle_inc  = {1'b0, cycle_count} + 1'b1;
    assign fast_fwd   = skip_idle && !out_valid && fifo_ne && ({1'b0, head_time} > cycle_inc);
    assign cycle_next = (&cycle_count) ? cycle_count :
                        fast_fwd       ? head_time   : cycle_inc[TIME_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_time[wr_ptr] <= in_time;
            mem_op[wr_ptr]   <= in_op;
            mem_addr[wr_ptr] <= in_address;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            cycle_count  <= '0;
            last_time    <= '0;
            order_err    <= 1'b0;
            stall_cycles <= '0;
            opcode       <= NOP;
            address      <= '0;
            out_time     <= '0;
            out_late     <= 1'b0;
        end else begin
            cycle_count <= cycle_next;

            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                last_time <= in_time;
                if (in_time < last_time)
                    order_err <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count_q <= count_q + OW'(1);
            else if (!push && pop)
                count_q <= count_q - OW'(1);

            if (out_valid && !out_ready && !(&stall_cycles))
                stall_cycles <= stall_cycles + STAT_WIDTH'(1);

            case (state_q)
                EMPTY, HOLD: begin
                    if (pop) begin
                        state_q  <= HOLD;
                        opcode   <= mem_op[rd_ptr];
                        address  <= mem_addr[rd_ptr];
                        out_time <= head_time;
                        out_late <= (cycle_count > head_time);
                    end else if (state_q == HOLD && out_ready) begin
                        state_q  <= EMPTY;
                        opcode   <= NOP;
                        address  <= '0;
                        out_time <= '0;
                        out_late <= 1'b0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: doc/trace_release_queue.md
Name: trace_release_queue

Overview:
- Parametrised successor to the trace-driven op source.
- Accepts already-parsed trace entries (time, op, address) over a valid/ready input, buffers them in a DEPTH-entry FIFO, and releases each entry to the memory-controller request path once the internal cycle counter reaches the entry's timestamp.
- Adds what the single-entry parser lacks: buffering, downstream backpressure, late-release tagging, out-of-order detection, and an optional idle fast-forward mode.

Parameters:
- ADDRESS_WIDTH, 33, address width; matches global_defs.
- TIME_WIDTH, 64, width of trace timestamps and cycle counter.
- DEPTH, 8, FIFO entries; power of two, >=2.
- STAT_WIDTH, 32, width of stall counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  trace entry offered.
- in_ready  out  1  entry accepted when in_valid&&in_ready.
- in_time  in  TIME_WIDTH  trace timestamp (CPU cycles).
- in_op  in  parsed_op_t  trace op (READ/WRITE/FETCH).
- in_address  in  ADDRESS_WIDTH  trace address.
- skip_idle  in  1  enable idle fast-forward (sampled every cycle).
- out_valid  out  1  released request present.
- out_ready  in  1  downstream consumes when out_valid&&out_ready.
- opcode  out  parsed_op_t  released op; NOP when !out_valid.
- address  out  ADDRESS_WIDTH  released address; 0 when !out_valid.
- out_time  out  TIME_WIDTH  timestamp of released entry.
- out_late  out  1  released entry loaded after its timestamp.
- cycle_count  out  TIME_WIDTH  current simulated cycle.
- occupancy  out  $clog2(DEPTH)+1  FIFO entries held (excludes output register).
- order_err  out  1  sticky: an entry with time < previous accepted time was seen.
- stall_cycles  out  STAT_WIDTH  cycles with out_valid&&!out_ready; saturating.

Behaviour:
- Reset (rst_n=0 at posedge clk): FIFO flushed, occupancy=0, cycle_count=0, out_valid=0, opcode=NOP, address=0, out_time=0, out_late=0, order_err=0, stall_cycles=0, last-accepted-time=0. Reset mid-operation discards all held and in-flight entries with no output.
- in_ready = (occupancy != DEPTH); combinational, no bypass. A push at full is impossible.
- cycle_count increments by 1 every non-reset cycle and saturates at all-ones.
- Fast-forward: if skip_idle=1, out_valid=0, FIFO non-empty and head.time > cycle_count+1, the next cycle_count = head.time instead of +1.
- Out-of-order entry (in_time < last accepted time): the entry is still accepted and order_err is set. It is released as soon as it reaches the head (already due).
- Output register FSM:
  - EMPTY: out_valid=0. Goes to HOLD when FIFO non-empty and head.time <= cycle_count.
  - HOLD: out_valid=1, output fields stable.
  - On out_ready, a pop-and-reload in the same cycle is allowed if the next head is due (back-to-back throughput of 1/cycle). Otherwise return to EMPTY.
- Load latency: an entry due at cycle T is visible on out_valid in the cycle where cycle_count = T+1, provided it was at the FIFO head and the register was free at T.
- Push latency: an entry pushed at cycle t is at the head no earlier than t+1.
- out_late = 1 when the load cycle's cycle_count > entry.time. This covers entries stalled by backpressure, FIFO ordering, or late arrival.
- stall_cycles increments on every cycle with out_valid&&!out_ready and saturates.
- Simultaneous push and pop: occupancy unchanged. FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset, push {time=5,READ,0x1F}; out_ready=1 -> out_valid high only at cycle_count=6, opcode=READ, address=0x1F, out_late=0, then NOP.
- Push times 10,10,10 (WRITE), out_ready=1 -> three consecutive out_valid cycles at cycle_count 11,12,13; out_late=0,1,1.
- Push time 3 with out_ready=0 for 4 cycles after release -> outputs held stable, stall_cycles=4, then consumed.
- Push DEPTH entries with time=1000, then offer one more -> in_ready=0 and occupancy=DEPTH. After one pop, in_ready=1.
- skip_idle=1, push time=1_000_000 at cycle 2 -> cycle_count jumps to 1_000_000, out_valid at 1_000_001. Repeat with skip_idle=0: no jump.
- Push times 20 then 8 -> order_err=1, second entry released directly after the first, out_late=1. Assert rst_n=0 mid-stream -> all outputs return to reset values next cycle.
